// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release sequencer with optional watchdog (RSTSEQ_WDT_EN)
module reset_sequencer #(
    parameter int NSTAGE     = 4,
    parameter int STAGE_DLY  = 64,
    parameter int CNTW       = 8,
    parameter int WDT_W      = 20,
    parameter int WDT_CYCLES = 1000000
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              SRST_REQ,
    input  logic              WDT_KICK,
    output logic [NSTAGE-1:0] RST_X_OUT,
    output logic              READY,
    output logic              SRST_ACK,
    output logic [1:0]        STATE,
    output logic              WDT_FIRED
);

    localparam logic [1:0] S_HOLD    = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;

    localparam int              IDXW     = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(STAGE_DLY - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSTAGE - 1);

    logic [1:0]        state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [NSTAGE-1:0] rst_out_q, rst_out_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic [1:0]        state_out_q, state_out_d;
    logic              wdt_timeout;
    logic              restart;

`ifdef RSTSEQ_WDT_EN
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_fired_q, wdt_fired_d;

    // Watchdog counts only while the visible state is RUN; a kick always beats a timeout
    always_comb begin
        wdt_timeout = 1'b0;
        wdt_cnt_d   = '0;
        if (ready_q && !WDT_KICK) begin
            if (wdt_cnt_q == WDT_LAST) begin
                wdt_timeout = 1'b1;
            end else begin
                wdt_cnt_d = wdt_cnt_q + 1'b1;
            end
        end
        wdt_fired_d = wdt_fired_q | wdt_timeout;
    end

    // Watchdog state; the fired flag is only cleared by RST_X
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            wdt_cnt_q   <= '0;
            wdt_fired_q <= 1'b0;
        end else begin
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_fired_q <= wdt_fired_d;
        end
    end

    assign WDT_FIRED = wdt_fired_q;
`else
    logic unused_wdt;
    assign unused_wdt  = WDT_KICK ^ (WDT_W > 0) ^ (WDT_CYCLES > 0);
    assign wdt_timeout = 1'b0;
    assign WDT_FIRED   = 1'b0;
`endif

    // A re-sequence is only honoured once RUN is visible on READY, never mid-sequence
    assign restart = ready_q && (SRST_REQ || wdt_timeout);

    // Next-state logic: delay counter, stage index and per-stage release bits
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        ack_d     = 1'b0;
        case (state_q)
            S_HOLD: begin
                rst_out_d = '0;
                if (cnt_q == CNT_LAST) begin
                    rst_out_d[0] = 1'b1;
                    cnt_d        = '0;
                    idx_d        = IDXW'(1);
                    state_d      = (NSTAGE == 1) ? S_RUN : S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (cnt_q == CNT_LAST) begin
                    rst_out_d[idx_q] = 1'b1;
                    cnt_d            = '0;
                    idx_d            = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d   = S_HOLD;
                cnt_d     = '0;
                idx_d     = '0;
                rst_out_d = '0;
            end
        endcase
        if (restart) begin
            state_d   = S_HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '0;
            ack_d     = 1'b1;
        end
        // READY/STATE report RUN one edge after the final release, but drop on the restart edge
        ready_d     = (state_q == S_RUN) && (state_d == S_RUN);
        state_out_d = ready_d ? S_RUN : ((state_d == S_RUN) ? state_q : state_d);
    end

    // Sequencer registers; every output comes straight from a flop
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_out_q   <= '0;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            state_out_q <= S_HOLD;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_out_q   <= rst_out_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            state_out_q <= state_out_d;
        end
    end

    assign RST_X_OUT = rst_out_q;
    assign READY     = ready_q;
    assign SRST_ACK  = ack_q;
    assign STATE     = state_out_q;

endmodule
